// File: rtl/tpu_pkg.sv
// Shared types for the systolic operand path: skew mode, skew FSM states and
// the drain counter width helper.
package tpu_pkg;

  typedef enum logic {
    SKEW_MODE   = 1'b0,
    DESKEW_MODE = 1'b1
  } skew_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } skew_state_e;

  // Width of a counter that must hold ARRAY_SIZE-1; never narrower than 1 bit.
  function automatic int drain_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skew_delay_lane.sv
// One lane's delay chain: DEPTH enable-gated registers. Tap t is the lane
// input delayed by t shifts (tap 0 is the input itself).
module skew_delay_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             en,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [(DEPTH+1)*DATA_WIDTH-1:0]  taps
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int j = 0; j < DEPTH; j++) stage_d[j] = stage_q[j];
    if (en) begin
      stage_d[0] = din;
      for (int j = 1; j < DEPTH; j++) stage_d[j] = stage_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int j = 0; j < DEPTH; j++) stage_q[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) stage_q[j] <= stage_d[j];
    end
  end

  always_comb begin
    taps[DATA_WIDTH-1:0] = din;
    for (int j = 0; j < DEPTH; j++) taps[(j+1)*DATA_WIDTH +: DATA_WIDTH] = stage_q[j];
  end

endmodule

// File: rtl/systolic_skew_buffer.sv
// Diagonal skew/deskew of ARRAY_SIZE-lane vectors for a systolic array, with
// automatic zero-padded drain after each frame.
module systolic_skew_buffer
  import tpu_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           srstn,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           busy,
  output skew_state_e                    dbg_state
);

  // Handshake: a beat moves on a side when its valid and ready are both high
  // at the rising edge; ready never depends on the same side's valid.

  localparam int VW = ARRAY_SIZE * DATA_WIDTH;
  localparam int CW = drain_cnt_w(ARRAY_SIZE);

  skew_state_e           state_q, state_d;
  skew_mode_e            mode_q, mode_d, mode_eff;
  logic [CW-1:0]         drain_cnt_q, drain_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [VW-1:0]         out_data_q, out_data_d;
  logic                  step, accept;
  logic [VW-1:0]         lane_in, tapped;
  logic [VW-1:0]         lane_taps [ARRAY_SIZE];

  assign step     = (!out_valid_q || out_ready) && ((state_q == DRAIN) || in_valid);
  assign accept   = step && (state_q != DRAIN);
  assign in_ready = srstn && (state_q != DRAIN) && (!out_valid_q || out_ready);
  assign lane_in  = (state_q == DRAIN) ? '0 : in_data;
  // The first beat of a frame already routes through the newly requested mode.
  assign mode_eff = (state_q == IDLE) ? skew_mode_e'(mode) : mode_q;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    skew_delay_lane #(
      .DEPTH      (ARRAY_SIZE - 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk   (clk),
      .srstn (srstn),
      .en    (step),
      .din   (lane_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .taps  (lane_taps[g])
    );
  end

  always_comb begin
    tapped = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      for (int t = 0; t < ARRAY_SIZE; t++) begin
        if (t == ((mode_eff == DESKEW_MODE) ? (ARRAY_SIZE - 1 - i) : i))
          tapped[i*DATA_WIDTH +: DATA_WIDTH] = lane_taps[i][t*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    drain_cnt_d = drain_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d = skew_mode_e'(mode);
          if (in_last) begin
            state_d     = DRAIN;
            drain_cnt_d = CW'(ARRAY_SIZE - 1);
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept && in_last) begin
          state_d     = DRAIN;
          drain_cnt_d = CW'(ARRAY_SIZE - 1);
        end
      end
      DRAIN: begin
        if (step) begin
          drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (step) begin
      out_valid_d = 1'b1;
      out_last_d  = (state_q == DRAIN) && (drain_cnt_q == CW'(1));
      out_data_d  = tapped;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q     <= IDLE;
      mode_q      <= SKEW_MODE;
      drain_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      drain_cnt_q <= drain_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE) || out_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Bench for systolic_skew_buffer at ARRAY_SIZE=4: scenario tasks drive frames,
// a formula-based model fills the expected queue, a negedge scoreboard checks.
module tb_systolic_skew_buffer;
  import tpu_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          srstn;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  skew_state_e   dbg_state;

  systolic_skew_buffer #(.ARRAY_SIZE(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .srstn     (srstn),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_pat = 0;   // 0: always ready, 1: toggle, 2: random

  logic [DW:0]   exp_q[$];
  logic [DW:0]   got_q[$];
  logic [DW-1:0] frame [16];
  int            frame_len;
  logic          stall_prev = 1'b0;
  logic [DW:0]   held;
  logic [DW:0]   exp_v;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_pat)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!srstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        checks++;
        if ({out_last, out_data} !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", {out_last, out_data}, held);
        end
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h want none", {out_last, out_data});
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_last, out_data} !== exp_v) begin
            errors++;
            $display("FAIL beat: got last=%b data=%h want last=%b data=%h",
                     out_last, out_data, exp_v[DW], exp_v[DW-1:0]);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_last, out_data};
    end
  end

  // ---------------- reference model ----------------
  // Beat k, lane i = row (k - d_i) when that row exists, otherwise zero.
  task automatic push_model(input int m);
    logic [DW-1:0] v;
    int d, r;
    for (int k = 0; k < frame_len + N - 1; k++) begin
      v = '0;
      for (int i = 0; i < N; i++) begin
        d = (m != 0) ? (N - 1 - i) : i;
        r = k - d;
        if (r >= 0 && r < frame_len) v[i*W +: W] = frame[r][i*W +: W];
      end
      exp_q.push_back({(k == frame_len + N - 2), v});
    end
  endtask

  task automatic fill_frame(input int len, input int base);
    frame_len = len;
    for (int r = 0; r < len; r++)
      for (int i = 0; i < N; i++)
        frame[r][i*W +: W] = 8'(16 * (r + base) + i + 1);
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic md, input int gap);
    logic acc;
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode     = md;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles want accept", n);
    end
  endtask

  task automatic send_frame(input int m, input int gap_mode);
    int gap;
    logic md;
    for (int r = 0; r < frame_len; r++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
      md  = (r == 0) ? m[0] : 1'($urandom_range(0, 1));
      send_beat(frame[r], (r == frame_len - 1), md, gap);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats pending want 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b out_valid=%b want 0 0", name, busy, out_valid);
    end
  endtask

  task automatic check_beat(input string name, input int k, input logic [DW:0] want);
    checks++;
    if (got_q.size() <= k) begin
      errors++;
      $display("FAIL %s_beat%0d: got %0d beats want beat present", name, k, got_q.size());
    end else if (got_q[k] !== want) begin
      errors++;
      $display("FAIL %s_beat%0d: got %h want %h", name, k, got_q[k], want);
    end
  endtask

  task automatic check_count(input string name, input int want);
    checks++;
    if (got_q.size() != want) begin
      errors++;
      $display("FAIL %s_count: got %0d want %0d", name, got_q.size(), want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    srstn = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset: got v=%b busy=%b rdy=%b last=%b data=%h st=%0d want all 0",
               out_valid, busy, in_ready, out_last, out_data, dbg_state);
    end
    @(negedge clk);
    srstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_skew_basic();
    ready_pat = 0;
    got_q.delete();
    fill_frame(4, 0);
    push_model(0);
    send_frame(0, 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (j == 3)) begin
        errors++;
        $display("FAIL skew_in_ready%0d: got %b want %b", j, in_ready, (j == 3));
      end
    end
    wait_drain("skew");
    check_count("skew", 7);
    check_beat("skew", 0, {1'b0, 32'h00000001});
    check_beat("skew", 3, {1'b0, 32'h04132231});
    check_beat("skew", 6, {1'b1, 32'h34000000});
  endtask

  task automatic test_deskew();
    ready_pat = 0;
    got_q.delete();
    fill_frame(4, 0);
    push_model(1);
    send_frame(1, 0);
    wait_drain("deskew");
    check_count("deskew", 7);
    check_beat("deskew", 0, {1'b0, 32'h04000000});
    check_beat("deskew", 3, {1'b0, 32'h34231201});
    check_beat("deskew", 6, {1'b1, 32'h00000031});
  endtask

  task automatic test_backpressure();
    ready_pat = 1;
    got_q.delete();
    fill_frame(4, 0);
    push_model(0);
    send_frame(0, 1);
    wait_drain("bp");
    ready_pat = 0;
    check_count("bp", 7);
    check_beat("bp", 3, {1'b0, 32'h04132231});
    check_beat("bp", 6, {1'b1, 32'h34000000});
  endtask

  task automatic test_single();
    ready_pat = 0;
    got_q.delete();
    fill_frame(1, 0);
    push_model(0);
    send_frame(0, 0);
    wait_drain("single");
    check_count("single", 4);
    check_beat("single", 0, {1'b0, 32'h00000001});
    check_beat("single", 1, {1'b0, 32'h00000200});
    check_beat("single", 3, {1'b1, 32'h04000000});
  endtask

  task automatic test_back_to_back();
    ready_pat = 2;
    got_q.delete();
    fill_frame(3, 0);
    push_model(0);
    send_frame(0, 2);
    fill_frame(5, 4);
    push_model(1);
    send_frame(1, 2);
    wait_drain("b2b");
    ready_pat = 0;
    check_count("b2b", 14);
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    ready_pat = 0;
    fill_frame(4, 0);
    push_model(0);
    send_frame(0, 0);
    while (exp_q.size() > 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    srstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b st=%0d want 0 0 0 0",
               out_valid, busy, in_ready, dbg_state);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    srstn = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
    fill_frame(4, 0);
    push_model(0);
    send_frame(0, 0);
    wait_drain("after_reset");
    check_count("after_reset", 7);
    check_beat("after_reset", 0, {1'b0, 32'h00000001});
    check_beat("after_reset", 3, {1'b0, 32'h04132231});
    check_beat("after_reset", 6, {1'b1, 32'h34000000});
  endtask

  task automatic test_random();
    int m;
    ready_pat = 2;
    for (int f = 0; f < 8; f++) begin
      frame_len = $urandom_range(1, 6);
      for (int r = 0; r < frame_len; r++) frame[r] = $urandom;
      m = $urandom_range(0, 1);
      push_model(m);
      send_frame(m, 2);
    end
    wait_drain("random");
    ready_pat = 0;
  endtask

  initial begin
    test_reset();
    test_skew_basic();
    test_deskew();
    test_backpressure();
    test_single();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got no completion want finish before 400000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_skew_buffer.md
Name: systolic_skew_buffer

Overview:
Hardware replacement for the software diagonal skewing that is applied today when systolic-array operands are packed into SRAM. The block accepts one ARRAY_SIZE-lane vector per beat and emits the vector with each lane delayed by a per-lane offset.
- SKEW mode: lane i delayed i beats. Used on the weight/input side.
- DESKEW mode: lane i delayed ARRAY_SIZE-1-i beats. Used on the output side, where it turns anti-diagonal results back into rows.
- After each frame the block drains automatically with zero padding.
- It sits between the SRAM read path and the PE array, or between the PE array and the output SRAM.

Parameters:
- ARRAY_SIZE, 16, number of lanes (PE rows/cols); must be >= 2.
- DATA_WIDTH, 8, bits per lane.

Ports:
- clk  in  1  clock, rising edge.
- srstn  in  1  reset, asynchronous, active-low.
- mode  in  1  0=SKEW, 1=DESKEW; sampled only on the first accepted beat of a frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  ARRAY_SIZE*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  1  marks the final vector of the frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output beat.
- out_data  out  ARRAY_SIZE*DATA_WIDTH  skewed vector, same lane packing as in_data.
- out_last  out  1  final beat of the drained frame.
- busy  out  1  high in RUN or DRAIN, or while out_valid is high.

Behaviour:
- Reset (async, srstn=0): state=IDLE; all delay-line registers, out_data, out_valid, out_last and the drain counter clear to 0; busy=0; in_ready=0 while srstn=0.
- Reset mid-frame discards the frame. The first frame after reset must see all-zero delay lines.
- step = (!out_valid || out_ready) && ((state!=DRAIN && in_valid) || state==DRAIN). All lane delay lines and output registers advance only on step.
- in_ready = (state!=DRAIN) && (!out_valid || out_ready). This is combinational from out_valid/out_ready; it has no dependency on in_valid.
- Per-lane delay d_i:
  - SKEW: d_i = i.
  - DESKEW: d_i = ARRAY_SIZE-1-i.
  - Lane i is a chain of d_i registers followed by the output register. A lane with d_i=0 is a direct pass to the output register.
  - Lane count is identical in both modes. mode_q selects which chain tap feeds each lane's output register.
- On step, the value shifted into each chain is the in_data lane (RUN/IDLE) or 0 (DRAIN). out_valid <= 1 on step; out_valid <= 0 when out_ready && !step.
- Latency: input beat k contributes lane i to output beat k+d_i. Output beat k appears on the cycle after the step that produced it.
- For a frame of L vectors: exactly L+ARRAY_SIZE-1 output beats. Beat k, lane i = row (k-d_i) lane i if 0 <= k-d_i < L, else 0.
- Input gaps (in_valid=0 in RUN): no step and no bubble inserted; alignment is preserved.
- Output backpressure (out_ready=0 with out_valid=1): everything holds, and out_data/out_last are stable.
- FSM:
  - IDLE: on an accepted beat, latch mode_q=mode. If in_last, go to DRAIN with drain_cnt=ARRAY_SIZE-1; else go to RUN.
  - RUN: on an accepted beat with in_last, go to DRAIN with drain_cnt=ARRAY_SIZE-1.
  - DRAIN: each step decrements drain_cnt. The step with drain_cnt==1 sets out_last=1 on the produced beat and moves to IDLE.
  - out_last clears when that beat is accepted.
- Because the drain shifts ARRAY_SIZE-1 zeros, all chains are zero on return to IDLE. A new frame may be accepted in IDLE in the same cycle the last beat is accepted.
- mode changes outside the first beat are ignored.
- drain_cnt width is $clog2(ARRAY_SIZE).

Decomposition:
- Shared package tpu_pkg:
  - mode enum (SKEW_MODE=0, DESKEW_MODE=1).
  - skew FSM state enum (IDLE, RUN, DRAIN).
  - localparam helper for the drain count width.
- One natural sub-module: skew_delay_lane. It has parameters DEPTH and DATA_WIDTH, an enable, a data input, and tap outputs. It is instantiated per lane with DEPTH=ARRAY_SIZE-1 plus a mode-selected tap, or with per-lane depth where the tap approach is not used.

Test Plan (ARRAY_SIZE=4, DATA_WIDTH=8, in row r lane i = 16*r+i+1):
- SKEW, L=4, out_ready=1, in_valid continuous -> 7 beats. Beat0 lanes3..0 = {0,0,0,0x01}; beat3 = {0x04,0x13,0x22,0x31}; beat6 = {0x34,0,0,0}; out_last only on beat6; in_ready=0 for the 3 drain cycles.
- DESKEW, L=4 -> beat0 = {0x04,0,0,0}; beat3 = {0x34,0x23,0x12,0x01}; beat6 = {0,0,0,0x31}; 7 beats total.
- SKEW, L=4 with out_ready toggling 1,0,1,0... and in_valid toggling 0,1 -> the accepted output sequence is identical to scenario 1; out_data is stable while stalled.
- Single-beat frame (in_last on the first beat), SKEW -> 4 beats, each with exactly one non-zero lane (lane k = 0x0k+1 on beat k); out_last on beat3.
- Back-to-back frames with mode flipped on the second frame's first beat -> the second frame follows the DESKEW pattern with no residue from the first; mode toggled mid-frame has no effect.
- Assert srstn=0 during DRAIN (after beat4 of scenario 1), release -> out_valid=0, busy=0 immediately; a following frame reproduces scenario 1 exactly.
